// File: rtl/vdp_pkg.sv
// Shared vdp99 definitions: VRAM geometry, control-byte decode values and
// the VRAM request sequencer state encoding.
package vdp_pkg;

  localparam int VRAM_AW = 14;

  localparam logic [1:0] CTL_RD_SETUP = 2'b00;
  localparam logic [1:0] CTL_WR_SETUP = 2'b01;
  localparam logic       CTL_REG      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } vram_state_e;

endpackage

// File: rtl/vdp_vram_req.sv
// VRAM req/ack sequencer: one access in flight plus a one-deep pending slot.
// Handshake: mem_req_o rises with we/addr/wdata and all hold until mem_ack_i.
module vdp_vram_req
  import vdp_pkg::*;
#(
  parameter int AW = VRAM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enq_i,
  input  logic          enq_we_i,
  input  logic [AW-1:0] enq_addr_i,
  input  logic [7:0]    enq_wdata_i,
  input  logic          mem_ack_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  output logic          busy_o,
  output logic          overrun_o,
  output vram_state_e   state_o
);

  vram_state_e   state_q, state_d;
  logic          cur_we_q, cur_we_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]    cur_wdata_q, cur_wdata_d;
  logic          pend_full_q, pend_full_d;
  logic          pend_we_q, pend_we_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_wdata_q, pend_wdata_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_we_q     <= 1'b0;
      cur_addr_q   <= '0;
      cur_wdata_q  <= '0;
      pend_full_q  <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_we_q     <= cur_we_d;
      cur_addr_q   <= cur_addr_d;
      cur_wdata_q  <= cur_wdata_d;
      pend_full_q  <= pend_full_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_we_d     = cur_we_q;
    cur_addr_d   = cur_addr_q;
    cur_wdata_d  = cur_wdata_q;
    pend_full_d  = pend_full_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = overrun_q;

    // Retire the ack first so a same-cycle enqueue sees the freed slot.
    if (mem_ack_i && state_q != ST_IDLE) begin
      if (pend_full_q) begin
        state_d     = pend_we_q ? ST_WR : ST_RD;
        cur_we_d    = pend_we_q;
        cur_addr_d  = pend_addr_q;
        cur_wdata_d = pend_wdata_q;
        pend_full_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (enq_i) begin
      if (state_d == ST_IDLE) begin
        state_d     = enq_we_i ? ST_WR : ST_RD;
        cur_we_d    = enq_we_i;
        cur_addr_d  = enq_addr_i;
        cur_wdata_d = enq_wdata_i;
      end else if (!pend_full_d) begin
        pend_full_d  = 1'b1;
        pend_we_d    = enq_we_i;
        pend_addr_d  = enq_addr_i;
        pend_wdata_d = enq_wdata_i;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign mem_req_o   = (state_q != ST_IDLE);
  assign mem_we_o    = cur_we_q;
  assign mem_addr_o  = cur_addr_q;
  assign mem_wdata_o = cur_wdata_q;
  assign busy_o      = (state_q != ST_IDLE) | pend_full_q;
  assign overrun_o   = overrun_q;
  assign state_o     = state_q;

endmodule

// File: rtl/vdp_vram_port.sv
// CPU-side VRAM data port: control-port address setup, auto-incrementing
// data-port accesses and the read-ahead buffer presented on dout.
module vdp_vram_port
  import vdp_pkg::*;
#(
  parameter int AW = VRAM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_tick,
  input  logic          rd0_tick,
  input  logic          wr1_tick,
  input  logic          rd1_tick,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          overrun
);

  logic [AW-1:0] addr_q, addr_d;
  logic          latch_q, latch_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    readbuf_q, readbuf_d;
  logic          enq;
  logic          enq_we;
  logic [AW-1:0] enq_addr;
  logic [AW-1:0] setup_addr;
  vram_state_e   req_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      latch_q   <= 1'b0;
      lo_q      <= '0;
      readbuf_q <= '0;
    end else begin
      addr_q    <= addr_d;
      latch_q   <= latch_d;
      lo_q      <= lo_d;
      readbuf_q <= readbuf_d;
    end
  end

  assign setup_addr = AW'({din[5:0], lo_q});

  always_comb begin
    addr_d    = addr_q;
    latch_d   = latch_q;
    lo_d      = lo_q;
    readbuf_d = readbuf_q;
    enq       = 1'b0;
    enq_we    = 1'b0;
    enq_addr  = addr_q;

    if (req_state == ST_RD && mem_ack) readbuf_d = mem_rdata;

    // A CPU write overrides read data landing in the same cycle.
    if (wr0_tick) begin
      latch_d   = 1'b0;
      readbuf_d = din;
      enq       = 1'b1;
      enq_we    = 1'b1;
      addr_d    = addr_q + AW'(1);
    end else if (rd0_tick) begin
      latch_d = 1'b0;
      enq     = 1'b1;
      addr_d  = addr_q + AW'(1);
    end else if (wr1_tick) begin
      if (!latch_q) begin
        lo_d    = din;
        latch_d = 1'b1;
      end else begin
        latch_d = 1'b0;
        if (din[7] != CTL_REG) begin
          if (din[7:6] == CTL_RD_SETUP) begin
            enq      = 1'b1;
            enq_addr = setup_addr;
            addr_d   = setup_addr + AW'(1);
          end else if (din[7:6] == CTL_WR_SETUP) begin
            addr_d = setup_addr;
          end
        end
      end
    end else if (rd1_tick) begin
      latch_d = 1'b0;
    end
  end

  assign dout = readbuf_q;

  vdp_vram_req #(.AW(AW)) u_req (
    .clk         (clk),
    .rst_n       (reset),
    .enq_i       (enq),
    .enq_we_i    (enq_we),
    .enq_addr_i  (enq_addr),
    .enq_wdata_i (din),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .state_o     (req_state)
  );

endmodule

// File: tb/tb_vdp_vram_port.sv
// Bench for vdp_vram_port: directed scenarios and random traffic checked
// against a queue-based model of the CPU port and its access backlog.
module tb_vdp_vram_port;

  logic        clk;
  logic        reset;
  logic        wr0_tick, rd0_tick, wr1_tick, rd1_tick;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy, overrun;

  vdp_vram_port dut (
    .clk       (clk),
    .reset     (reset),
    .wr0_tick  (wr0_tick),
    .rd0_tick  (rd0_tick),
    .wr1_tick  (wr1_tick),
    .rd1_tick  (rd1_tick),
    .din       (din),
    .dout      (dout),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: outstanding accesses in issue order (front = on the bus)
  typedef struct { bit we; int unsigned addr; bit [7:0] wdata; } acc_t;
  acc_t        exp_q[$];
  int unsigned m_addr;
  bit          m_latch;
  int unsigned m_lo;
  bit [7:0]    m_readbuf;
  bit          m_ovr;

  task automatic model_reset();
    exp_q.delete();
    m_addr = 0; m_latch = 0; m_lo = 0; m_readbuf = 0; m_ovr = 0;
  endtask

  task automatic model_push(input bit we, input int unsigned a, input bit [7:0] d);
    acc_t x;
    x.we = we; x.addr = a; x.wdata = d;
    if (exp_q.size() < 2) exp_q.push_back(x);
    else m_ovr = 1;
  endtask

  task automatic model_cycle(input bit w0, r0, w1, r1, input bit [7:0] d,
                             input bit ack, input bit [7:0] rd);
    int unsigned sa;
    if (ack && exp_q.size() > 0) begin
      acc_t x = exp_q.pop_front();
      if (!x.we) m_readbuf = rd;
    end
    if (w0) begin
      m_latch = 0; m_readbuf = d;
      model_push(1, m_addr, d);
      m_addr = (m_addr + 1) % 16384;
    end else if (r0) begin
      m_latch = 0;
      model_push(0, m_addr, d);
      m_addr = (m_addr + 1) % 16384;
    end else if (w1) begin
      if (!m_latch) begin
        m_lo = d; m_latch = 1;
      end else begin
        m_latch = 0;
        sa = (d % 64) * 256 + m_lo;
        if (d / 64 == 0) begin
          model_push(0, sa, d);
          m_addr = (sa + 1) % 16384;
        end else if (d / 64 == 1) begin
          m_addr = sa;
        end
      end
    end else if (r1) begin
      m_latch = 0;
    end
  endtask

  task automatic compare_all();
    check_val("mem_req", mem_req, exp_q.size() > 0);
    check_val("busy", busy, exp_q.size() > 0);
    check_val("overrun", overrun, m_ovr);
    check_val("dout", dout, m_readbuf);
    if (exp_q.size() > 0) begin
      check_val("mem_we", mem_we, exp_q[0].we);
      check_val("mem_addr", mem_addr, exp_q[0].addr);
      if (exp_q[0].we) check_val("mem_wdata", mem_wdata, exp_q[0].wdata);
    end
  endtask

  // driver: one clock with the given inputs, called and returning at negedge
  task automatic step(input bit w0, r0, w1, r1, input bit [7:0] d,
                      input bit ack, input bit [7:0] rd);
    wr0_tick = w0; rd0_tick = r0; wr1_tick = w1; rd1_tick = r1;
    din = d; mem_ack = ack; mem_rdata = rd;
    model_cycle(w0, r0, w1, r1, d, ack, rd);
    @(negedge clk);
    wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0; mem_ack = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      step(0, 0, 0, 0, 8'h00, 1, 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    model_reset();
    reset = 1;
    compare_all();
  endtask

  initial begin
    reset = 0;
    wr0_tick = 0; rd0_tick = 0; wr1_tick = 0; rd1_tick = 0;
    din = 0; mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_dout", dout, 8'h00);
    check_val("rst_req", mem_req, 1'b0);
    check_val("rst_we", mem_we, 1'b0);
    check_val("rst_addr", mem_addr, 14'h0);
    check_val("rst_wdata", mem_wdata, 8'h00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ovr", overrun, 1'b0);
    reset = 1;

    // read setup
    step(0, 0, 1, 0, 8'h34, 0, 0);
    step(0, 0, 1, 0, 8'h12, 0, 0);
    check_val("rs_addr", mem_addr, 14'h1234);
    check_val("rs_we", mem_we, 1'b0);
    idle(2);
    step(0, 0, 0, 0, 8'h00, 1, 8'hAB);
    check_val("rs_dout", dout, 8'hAB);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    check_val("rs_next", mem_addr, 14'h1235);
    drain();

    // write setup, back-to-back writes
    do_reset();
    step(0, 0, 1, 0, 8'h00, 0, 0);
    step(0, 0, 1, 0, 8'h40, 0, 0);
    step(1, 0, 0, 0, 8'h55, 0, 0);
    step(1, 0, 0, 0, 8'h66, 0, 0);
    check_val("ws_a0", mem_addr, 14'h0000);
    check_val("ws_d0", mem_wdata, 8'h55);
    idle(3);
    step(0, 0, 0, 0, 8'h00, 1, 0);
    check_val("ws_req_held", mem_req, 1'b1);
    check_val("ws_a1", mem_addr, 14'h0001);
    check_val("ws_d1", mem_wdata, 8'h66);
    check_val("ws_dout", dout, 8'h66);
    idle(3);
    step(0, 0, 0, 0, 8'h00, 1, 0);
    check_val("ws_busy", busy, 1'b0);

    // address wrap
    step(0, 0, 1, 0, 8'hFF, 0, 0);
    step(0, 0, 1, 0, 8'h7F, 0, 0);
    step(1, 0, 0, 0, 8'h11, 0, 0);
    step(1, 0, 0, 0, 8'h22, 0, 0);
    check_val("wrap_a0", mem_addr, 14'h3FFF);
    step(0, 0, 0, 0, 8'h00, 1, 0);
    check_val("wrap_a1", mem_addr, 14'h0000);
    drain();

    // register write, then rd1 clearing a half-written address
    do_reset();
    step(0, 0, 1, 0, 8'h07, 0, 0);
    step(0, 0, 1, 0, 8'h87, 0, 0);
    check_val("reg_noreq", mem_req, 1'b0);
    step(0, 0, 0, 1, 8'h00, 0, 0);
    step(0, 0, 1, 0, 8'h10, 0, 0);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check_val("reg_rd_addr", mem_addr, 14'h0010);
    drain();
    step(0, 0, 1, 0, 8'h99, 0, 0);
    step(0, 0, 0, 1, 8'h00, 0, 0);
    step(0, 0, 1, 0, 8'h20, 0, 0);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    check_val("rd1_latch", mem_addr, 14'h0020);
    drain();

    // overrun
    do_reset();
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    check_val("ovr_set", overrun, 1'b1);
    step(0, 0, 0, 0, 8'h00, 1, 8'h01);
    step(0, 0, 0, 0, 8'h00, 1, 8'h02);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    check_val("ovr_addr", mem_addr, 14'h0003);
    drain();

    // ack coincident with enqueue
    do_reset();
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 1, 8'h44);
    check_val("coinc_ovr", overrun, 1'b0);
    check_val("coinc_addr", mem_addr, 14'h0001);
    drain();

    // wr0 coincident with a read ack
    do_reset();
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h5A, 1, 8'hC3);
    check_val("wr_wins", dout, 8'h5A);
    drain();

    // reset mid-access
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'h00, 1, 8'h9E);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    #2 reset = 0;
    #1;
    check_val("arst_req", mem_req, 1'b0);
    check_val("arst_dout", dout, 8'h00);
    check_val("arst_addr", mem_addr, 14'h0);
    check_val("arst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      bit ack;
      k = $urandom_range(0, 9);
      ack = (exp_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      step(k == 0, k == 1, (k == 2) || (k == 3), k == 4, 8'($urandom), ack, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
